// File: rtl/noc_pkg.sv
// Shared ring-NoC types: packet layout, ring slot and packet type codes.
package noc_pkg;

    typedef enum logic [3:0] {
        memory_read_request  = 4'd0,
        memory_read_reply    = 4'd1,
        memory_write_request = 4'd2,
        memory_write_reply   = 4'd3
    } packet_type;

    typedef struct packed {
        packet_type    pt;
        logic [7:0]    id;
        logic [7:0]    dst_addr;
        logic [3:0]    dst_prt;
        logic [7:0]    src_addr;
        logic [3:0]    src_prt;
        logic [127:0]  dat;
    } packet;

    typedef struct packed {
        logic  valid;
        packet pkt;
    } noc_bus;

endpackage

// File: rtl/noc_ip_port.sv
// ip_port: bundle of the local-side signals between a ring stop and its IP block.
interface ip_port;
    import noc_pkg::*;

    packet dat_to_noc;
    logic  tx_submit;
    logic  tx_complete;
    packet dat_from_noc;
    logic  rx_recieve;
    logic  rx_complete;

    modport stop (input dat_to_noc, tx_submit, rx_complete,
                  output tx_complete, dat_from_noc, rx_recieve);
    modport ip   (output dat_to_noc, tx_submit, rx_complete,
                  input tx_complete, dat_from_noc, rx_recieve);
endinterface

// File: rtl/noc_stop_rx_buf.sv
// One-entry receive holding register: load wins over clear on the same edge.
module noc_stop_rx_buf
    import noc_pkg::*;
(
    input  logic  fclk,
    input  logic  rst,
    input  logic  load,
    input  packet load_pkt,
    input  logic  clear,
    output logic  full,
    output packet data
);

    // NOTE: the data register is reset too, so dat_from_noc reads zero after reset
    // rather than X; it is a single entry, not a RAM array.
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples pre-edge values regardless of statement order.
            full <= 1'b1;
            data <= load_pkt;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_stop_unit.sv
// Ring NoC stop: 1-cycle transit, local capture into a 1-entry buffer, local injection.
// Optional build macro NOC_STOP_TRACE_EN enables simulation trace of captures/injections.
module noc_stop_unit
    import noc_pkg::*;
#(
    parameter logic [7:0] ADDR = 8'd0,
    parameter logic [3:0] PORT = 4'd0
) (
    input  logic       fclk,
    input  logic       rst,
    input  noc_bus     noc_bus_inp,
    output noc_bus     noc_bus_oup,
    input  packet      dat_to_noc,
    input  logic       tx_submit,
    output logic       tx_complete,
    output packet      dat_from_noc,
    output logic       rx_recieve,
    input  logic       rx_complete,
    output logic [7:0] port_address,
    output logic [3:0] port_number
);

    logic   match;
    logic   capture;
    logic   forward;
    logic   inject;
    logic   armed;
    noc_bus slot_next;

    assign port_address = ADDR;
    assign port_number  = PORT;

    // A full buffer being emptied this cycle still counts as free.
    assign match   = noc_bus_inp.valid
                   && (noc_bus_inp.pkt.dst_addr == ADDR)
                   && (noc_bus_inp.pkt.dst_prt  == PORT);
    assign capture = match && (!rx_recieve || rx_complete);
    assign forward = noc_bus_inp.valid && !capture;
    assign inject  = !forward && tx_submit && armed;

    always_comb begin
        // NOTE: default first so every path assigns slot_next and no latch is inferred.
        slot_next = '0;
        if (forward) begin
            slot_next = noc_bus_inp;
        end else if (inject) begin
            slot_next.valid = 1'b1;
            slot_next.pkt   = dat_to_noc;
        end
    end

    // Re-arm only once tx_submit has been seen low, so a held request injects once.
    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            noc_bus_oup <= '0;
            tx_complete <= 1'b0;
            armed       <= 1'b1;
        end else begin
            noc_bus_oup <= slot_next;
            tx_complete <= inject;
            if (inject)
                armed <= 1'b0;
            else if (!tx_submit)
                armed <= 1'b1;
        end
    end

    noc_stop_rx_buf u_rx_buf (
        .fclk     (fclk),
        .rst      (rst),
        .load     (capture),
        .load_pkt (noc_bus_inp.pkt),
        .clear    (rx_complete),
        .full     (rx_recieve),
        .data     (dat_from_noc)
    );

`ifdef NOC_STOP_TRACE_EN
    always @(posedge fclk) begin
        if (rst && capture)
            $display("noc_stop %0d/%0d rx type=%s id=%0d dst=%0d/%0d", ADDR, PORT,
                     noc_bus_inp.pkt.pt.name(), noc_bus_inp.pkt.id,
                     noc_bus_inp.pkt.dst_addr, noc_bus_inp.pkt.dst_prt);
        if (rst && inject)
            $display("noc_stop %0d/%0d tx type=%s id=%0d dst=%0d/%0d", ADDR, PORT,
                     dat_to_noc.pt.name(), dat_to_noc.id,
                     dat_to_noc.dst_addr, dat_to_noc.dst_prt);
    end
`else
`endif

endmodule

// File: tb/tb_noc_stop_unit.sv
// Directed bench for noc_stop_unit (ADDR=1, PORT=2) with hand-computed expectations.
module tb_noc_stop_unit;
    import noc_pkg::*;

    logic       fclk = 1'b0;
    logic       rst;
    noc_bus     noc_bus_inp;
    noc_bus     noc_bus_oup;
    packet      dat_to_noc;
    logic       tx_submit;
    logic       tx_complete;
    packet      dat_from_noc;
    logic       rx_recieve;
    logic       rx_complete;
    logic [7:0] port_address;
    logic [3:0] port_number;

    int n_cmp = 0;
    int n_err = 0;

    noc_stop_unit #(8'd1, 4'd2) dut (
        .fclk         (fclk),
        .rst          (rst),
        .noc_bus_inp  (noc_bus_inp),
        .noc_bus_oup  (noc_bus_oup),
        .dat_to_noc   (dat_to_noc),
        .tx_submit    (tx_submit),
        .tx_complete  (tx_complete),
        .dat_from_noc (dat_from_noc),
        .rx_recieve   (rx_recieve),
        .rx_complete  (rx_complete),
        .port_address (port_address),
        .port_number  (port_number)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [164:0] got, input logic [164:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic packet mk(input packet_type t, input logic [7:0] id,
                                 input logic [7:0] da, input logic [3:0] dp,
                                 input logic [127:0] dat);
        packet p;
        p.pt = t; p.id = id; p.dst_addr = da; p.dst_prt = dp;
        p.src_addr = 8'h07; p.src_prt = 4'h1; p.dat = dat;
        return p;
    endfunction

    function automatic noc_bus slot(input packet p);
        noc_bus b;
        b.valid = 1'b1; b.pkt = p;
        return b;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    packet p_tr, p_pm, p_a, p_b, p_c, p_l, p_l2;
    packet t0, t1, t2;

    initial begin
        p_tr = mk(memory_read_request,  8'd5,  8'd3, 4'd0, 128'h1111);
        p_pm = mk(memory_write_request, 8'd6,  8'd1, 4'd3, 128'h2222);
        p_a  = mk(memory_read_reply,    8'd7,  8'd1, 4'd2, 128'hDEAD);
        p_b  = mk(memory_write_reply,   8'd9,  8'd1, 4'd2, 128'hBEEF);
        p_c  = mk(memory_read_request,  8'd10, 8'd1, 4'd2, 128'hCAFE);
        p_l  = mk(memory_read_request,  8'd20, 8'd4, 4'd1, 128'h5555);
        p_l2 = mk(memory_write_request, 8'd21, 8'd5, 4'd0, 128'h6666);
        t0   = mk(memory_read_request,  8'd30, 8'd2, 4'd0, 128'hA0);
        t1   = mk(memory_read_request,  8'd31, 8'd2, 4'd1, 128'hA1);
        t2   = mk(memory_read_request,  8'd32, 8'd2, 4'd2, 128'hA2);

        rst = 1'b0; noc_bus_inp = '0; dat_to_noc = p_l; tx_submit = 1'b0; rx_complete = 1'b0;
        #12;
        check("reset_oup", noc_bus_oup, '0);
        check("reset_rx", {164'd0, rx_recieve}, 165'd0);
        check("reset_dat", {1'b0, dat_from_noc}, 165'd0);
        check("reset_txc", {164'd0, tx_complete}, 165'd0);
        check("port_address", {157'd0, port_address}, 165'd1);
        check("port_number", {161'd0, port_number}, 165'd2);
        rst = 1'b1;
        step();

        // Transit, including address match with port mismatch
        noc_bus_inp = slot(p_tr); step();
        check("transit_oup", noc_bus_oup, slot(p_tr));
        check("transit_rx", {164'd0, rx_recieve}, 165'd0);
        noc_bus_inp = slot(p_pm); step();
        check("portmiss_oup", noc_bus_oup, slot(p_pm));
        check("portmiss_rx", {164'd0, rx_recieve}, 165'd0);
        noc_bus_inp = '0; step();
        check("idle_oup", noc_bus_oup, '0);

        // Delivery, then full buffer forwards a second match
        noc_bus_inp = slot(p_a); step();
        check("deliver_rx", {164'd0, rx_recieve}, 165'd1);
        check("deliver_dat", {37'd0, dat_from_noc.dat}, {37'd0, 128'hDEAD});
        check("deliver_oup_valid", {164'd0, noc_bus_oup.valid}, 165'd0);
        noc_bus_inp = slot(p_b); step();
        check("full_fwd_oup", noc_bus_oup, slot(p_b));
        check("full_hold_dat", {1'b0, dat_from_noc}, {1'b0, p_a});
        noc_bus_inp = '0; rx_complete = 1'b1; step();
        check("consume_rx", {164'd0, rx_recieve}, 165'd0);
        step();
        check("empty_complete_rx", {164'd0, rx_recieve}, 165'd0);

        // Capture on the same edge that frees the buffer
        rx_complete = 1'b0; noc_bus_inp = slot(p_a); step();
        noc_bus_inp = slot(p_c); rx_complete = 1'b1; step();
        check("refill_rx", {164'd0, rx_recieve}, 165'd1);
        check("refill_dat", {1'b0, dat_from_noc}, {1'b0, p_c});
        check("refill_oup", noc_bus_oup, '0);
        noc_bus_inp = '0; step();
        rx_complete = 1'b0;
        check("refill_consumed_rx", {164'd0, rx_recieve}, 165'd0);

        // Local capture plus injection on the same edge
        noc_bus_inp = slot(p_a); tx_submit = 1'b1; dat_to_noc = p_l; step();
        check("cap_inj_oup", noc_bus_oup, slot(p_l));
        check("cap_inj_txc", {164'd0, tx_complete}, 165'd1);
        check("cap_inj_rx", {164'd0, rx_recieve}, 165'd1);
        noc_bus_inp = '0; tx_submit = 1'b0; rx_complete = 1'b1; step();
        rx_complete = 1'b0;
        check("cap_inj_txc_drop", {164'd0, tx_complete}, 165'd0);

        // Held submit injects once; re-arms after a low sample
        tx_submit = 1'b1; dat_to_noc = p_l2; step();
        check("inj1_oup", noc_bus_oup, slot(p_l2));
        check("inj1_txc", {164'd0, tx_complete}, 165'd1);
        step();
        check("inj2_oup", noc_bus_oup, '0);
        check("inj2_txc", {164'd0, tx_complete}, 165'd0);
        tx_submit = 1'b0; step();
        check("inj3_txc", {164'd0, tx_complete}, 165'd0);
        tx_submit = 1'b1; dat_to_noc = p_l; step();
        check("rearm_txc", {164'd0, tx_complete}, 165'd1);
        tx_submit = 1'b0; step();

        // Contention: three transit packets delay the injection
        tx_submit = 1'b1; dat_to_noc = p_l2;
        noc_bus_inp = slot(t0); step();
        check("cont0_oup", noc_bus_oup, slot(t0));
        check("cont0_txc", {164'd0, tx_complete}, 165'd0);
        noc_bus_inp = slot(t1); step();
        check("cont1_oup", noc_bus_oup, slot(t1));
        check("cont1_txc", {164'd0, tx_complete}, 165'd0);
        noc_bus_inp = slot(t2); step();
        check("cont2_oup", noc_bus_oup, slot(t2));
        check("cont2_txc", {164'd0, tx_complete}, 165'd0);
        noc_bus_inp = '0; step();
        check("cont3_oup", noc_bus_oup, slot(p_l2));
        check("cont3_txc", {164'd0, tx_complete}, 165'd1);
        tx_submit = 1'b0; step();

        // Asynchronous reset mid-operation
        noc_bus_inp = slot(p_a); step();
        noc_bus_inp = slot(p_tr); step();
        check("pre_rst_rx", {164'd0, rx_recieve}, 165'd1);
        check("pre_rst_oup", noc_bus_oup, slot(p_tr));
        #2 rst = 1'b0;
        #1;
        check("async_rst_rx", {164'd0, rx_recieve}, 165'd0);
        check("async_rst_oup", noc_bus_oup, '0);
        check("async_rst_dat", {1'b0, dat_from_noc}, 165'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
